branch_resolve_unit: RTL and testbench

Buffers branch instructions issued from decode, drives the existing Branch_Comparator one branch at a time, and resolves each branch against its static prediction. For each branch it returns a resolution record to the commit stage and, on a mispredict, a one-cycle redirect to fetch. On a mispredict it squashes younger buffered branches. It also keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve_unit_pkg.sv | 24 ++
 rtl/branch_resolve_unit_cmp.sv | 26 ++
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// branch_pkg: shared widths, compare-op encodings and the buffered branch entry.
package branch_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_BLTU = 3'b100;
  localparam logic [2:0] BR_BGEU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      op;
    logic            pred_taken;
  } br_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_cmp.sv
`default_nettype none
// Branch_Comparator: evaluates a conditional-branch compare; undefined ops give 0.
module Branch_Comparator
  import branch_pkg::*;
(
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      branch_op,
  output logic            branch_result
);

  always_comb begin
    branch_result = 1'b0;
    case (branch_op)
      BR_BEQ:  branch_result = (rs1_data == rs2_data);
      BR_BNE:  branch_result = (rs1_data != rs2_data);
      BR_BLT:  branch_result = ($signed(rs1_data) <  $signed(rs2_data));
      BR_BGE:  branch_result = ($signed(rs1_data) >= $signed(rs2_data));
      BR_BLTU: branch_result = (rs1_data <  rs2_data);
      BR_BGEU: branch_result = (rs1_data >= rs2_data);
      default: branch_result = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// branch_resolve_unit: in-order branch buffer that resolves branches against their
// static prediction, emits commit records and mispredict redirects, and keeps stats.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [2:0]      req_op,
  input  logic            req_pred_taken,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_pc,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] cnt_branches,
  output logic [XLEN-1:0] cnt_mispredict,
  input  logic            test_cnt_load,
  input  logic [XLEN-1:0] test_cnt_value
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  br_entry_t       fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            res_valid_q, res_taken_q, res_mispredict_q;
  logic [XLEN-1:0] res_pc_q, redirect_pc_q, cnt_br_q, cnt_mis_q;

  br_entry_t       req_entry, head;
  logic            push, load, resolve, redirect, cmp_taken;
  logic [XLEN-1:0] head_target;

  assign req_entry = '{pc: req_pc, imm: req_imm, rs1: req_rs1, rs2: req_rs2,
                       op: req_op, pred_taken: req_pred_taken};
  assign head      = fifo_q[rd_ptr_q];

  Branch_Comparator u_cmp (
    .rs1_data      (head.rs1),
    .rs2_data      (head.rs2),
    .branch_op     (head.op),
    .branch_result (cmp_taken)
  );

  assign head_target = cmp_taken ? (head.pc + head.imm) : (head.pc + 32'd4);

  // A waiting mispredict stalls decode so nothing younger slips past the squash.
  assign req_ready = (count_q < DEPTH_C) && !flush && !(res_valid_q && res_mispredict_q);
  assign push      = req_valid && req_ready;
  assign resolve   = res_valid_q && res_ready;
  assign redirect  = resolve && res_mispredict_q;
  assign load      = (count_q != '0) && (!res_valid_q || res_ready) && !redirect && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush || redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (load) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, load})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      res_valid_q      <= 1'b0;
      res_pc_q         <= '0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_br_q         <= '0;
      cnt_mis_q        <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (flush)        res_valid_q <= 1'b0;
      else if (load)    res_valid_q <= 1'b1;
      else if (resolve) res_valid_q <= 1'b0;
      if (load) begin
        res_pc_q         <= head.pc;
        res_taken_q      <= cmp_taken;
        res_mispredict_q <= cmp_taken != head.pred_taken;
        redirect_pc_q    <= head_target;
      end
      // Counters survive flush; only reset or the preload hook touches them otherwise.
      if (test_cnt_load) begin
        cnt_br_q  <= test_cnt_value;
        cnt_mis_q <= test_cnt_value;
      end else if (resolve) begin
        if (cnt_br_q != '1) cnt_br_q <= cnt_br_q + 1'b1;
        if (res_mispredict_q && (cnt_mis_q != '1)) cnt_mis_q <= cnt_mis_q + 1'b1;
      end
    end
  end

  assign res_valid      = res_valid_q;
  assign res_pc         = res_pc_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign redirect_valid = redirect;
  assign redirect_pc    = redirect_pc_q;
  assign cnt_branches   = cnt_br_q;
  assign cnt_mispredict = cnt_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// tb_branch_resolve_unit: directed vectors with hand-computed expectations.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_ready, req_pred_taken;
  logic [31:0] req_pc, req_imm, req_rs1, req_rs2;
  logic [2:0]  req_op;
  logic        res_valid, res_ready, res_taken, res_mispredict, redirect_valid;
  logic [31:0] res_pc, redirect_pc, cnt_branches, cnt_mispredict;
  logic        test_cnt_load;
  logic [31:0] test_cnt_value;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_op(req_op), .req_pred_taken(req_pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cnt_branches(cnt_branches), .cnt_mispredict(cnt_mispredict),
    .test_cnt_load(test_cnt_load), .test_cnt_value(test_cnt_value)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op, input logic pred);
    req_valid = 1'b1; req_pc = pc; req_imm = imm; req_rs1 = a; req_rs2 = b;
    req_op = op; req_pred_taken = pred;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0; req_op = '0; req_pred_taken = 1'b0;
    test_cnt_load = 1'b0; test_cnt_value = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_pc", res_pc, 0);
    check_eq("rst_redirect", redirect_valid, 0);
    check_eq("rst_cnt_br", cnt_branches, 0);
    check_eq("rst_cnt_mis", cnt_mispredict, 0);

    // Single BEQ taken against a not-taken prediction.
    res_ready = 1'b1;
    offer(32'h100, 32'h20, 5, 5, BR_BEQ, 1'b0);
    step; req_valid = 1'b0;
    check_eq("s1_not_yet", res_valid, 0);
    step;
    check_eq("s1_valid", res_valid, 1);
    check_eq("s1_pc", res_pc, 32'h100);
    check_eq("s1_taken", res_taken, 1);
    check_eq("s1_mis", res_mispredict, 1);
    check_eq("s1_redir_v", redirect_valid, 1);
    check_eq("s1_redir_pc", redirect_pc, 32'h120);
    step;
    check_eq("s1_done", res_valid, 0);
    check_eq("s1_cnt_br", cnt_branches, 1);
    check_eq("s1_cnt_mis", cnt_mispredict, 1);

    // Signed vs unsigned compare on the same operands, both predicted correctly.
    offer(32'h140, 32'h10, 32'hFFFF_FFFF, 1, BR_BLT, 1'b1);
    step;
    offer(32'h144, 32'h10, 32'hFFFF_FFFF, 1, BR_BLTU, 1'b0);
    step; req_valid = 1'b0; #1;
    check_eq("s2_blt_pc", res_pc, 32'h140);
    check_eq("s2_blt_taken", res_taken, 1);
    check_eq("s2_blt_mis", res_mispredict, 0);
    check_eq("s2_blt_redir", redirect_valid, 0);
    step;
    check_eq("s2_bltu_pc", res_pc, 32'h144);
    check_eq("s2_bltu_taken", res_taken, 0);
    check_eq("s2_bltu_redir", redirect_valid, 0);
    step;
    check_eq("s2_cnt_br", cnt_branches, 3);
    check_eq("s2_cnt_mis", cnt_mispredict, 1);

    // Backpressure: output holds, FIFO fills, drain preserves order.
    res_ready = 1'b0;
    offer(32'h200, 0, 1, 2, BR_BEQ, 1'b0); step;
    offer(32'h204, 0, 1, 2, BR_BEQ, 1'b0); step;
    offer(32'h208, 0, 1, 2, BR_BEQ, 1'b0); step;
    offer(32'h20C, 0, 1, 2, BR_BEQ, 1'b0); #1;
    check_eq("s3_full_ready", req_ready, 0);
    check_eq("s3_head_valid", res_valid, 1);
    check_eq("s3_head_pc", res_pc, 32'h200);
    step;
    check_eq("s3_hold_pc", res_pc, 32'h200);
    check_eq("s3_hold_ready", req_ready, 0);
    res_ready = 1'b1;
    step;
    check_eq("s3_drain_b", res_pc, 32'h204);
    check_eq("s3_ready_back", req_ready, 1);
    step; req_valid = 1'b0;
    check_eq("s3_drain_c", res_pc, 32'h208);
    step;
    check_eq("s3_drain_d", res_pc, 32'h20C);
    step;
    check_eq("s3_empty", res_valid, 0);
    check_eq("s3_cnt_br", cnt_branches, 7);

    // Mispredict squashes the buffered younger branch and blocks a new one.
    res_ready = 1'b0;
    offer(32'h300, 32'h10, 1, 1, BR_BEQ, 1'b1); step;
    offer(32'h304, 32'h40, 3, 3, BR_BNE, 1'b1); step;
    offer(32'h308, 32'h10, 0, 0, BR_BEQ, 1'b1); step;
    offer(32'h30C, 32'h10, 0, 0, BR_BEQ, 1'b1);
    res_ready = 1'b1; #1;
    check_eq("s4_a_pc", res_pc, 32'h300);
    check_eq("s4_a_redir", redirect_valid, 0);
    step;
    check_eq("s4_m_pc", res_pc, 32'h304);
    check_eq("s4_m_mis", res_mispredict, 1);
    check_eq("s4_m_redir", redirect_valid, 1);
    check_eq("s4_m_target", redirect_pc, 32'h308);
    check_eq("s4_stall", req_ready, 0);
    step; req_valid = 1'b0; #1;
    check_eq("s4_sq_valid", res_valid, 0);
    check_eq("s4_sq_ready", req_ready, 1);
    check_eq("s4_sq_redir", redirect_valid, 0);
    step; step;
    check_eq("s4_no_young", res_valid, 0);
    check_eq("s4_cnt_br", cnt_branches, 9);
    check_eq("s4_cnt_mis", cnt_mispredict, 2);

    // Address wraparound on both taken and fall-through targets.
    offer(32'hFFFF_FFFC, 8, 7, 7, BR_BEQ, 1'b0); step; req_valid = 1'b0;
    step;
    check_eq("s5_wrap_taken", redirect_pc, 32'h4);
    check_eq("s5_wrap_redir", redirect_valid, 1);
    step;
    offer(32'hFFFF_FFFC, 8, 7, 7, BR_BNE, 1'b1); step; req_valid = 1'b0;
    step;
    check_eq("s5_wrap_nt", redirect_pc, 32'h0);
    check_eq("s5_nt_taken", res_taken, 0);
    check_eq("s5_nt_mis", res_mispredict, 1);
    step;
    check_eq("s5_cnt_br", cnt_branches, 11);
    check_eq("s5_cnt_mis", cnt_mispredict, 4);

    // Flush with FIFO full and a record waiting.
    res_ready = 1'b0;
    offer(32'h400, 0, 1, 2, BR_BEQ, 1'b0); step;
    offer(32'h404, 0, 1, 2, BR_BEQ, 1'b0); step;
    offer(32'h408, 0, 1, 2, BR_BEQ, 1'b0); step;
    req_valid = 1'b0;
    check_eq("s6_pre_valid", res_valid, 1);
    check_eq("s6_pre_ready", req_ready, 0);
    flush = 1'b1;
    step; flush = 1'b0; #1;
    check_eq("s6_fl_valid", res_valid, 0);
    check_eq("s6_fl_ready", req_ready, 1);
    check_eq("s6_fl_cnt_br", cnt_branches, 11);
    check_eq("s6_fl_cnt_mis", cnt_mispredict, 4);
    res_ready = 1'b1;
    step; step;
    check_eq("s6_fifo_empty", res_valid, 0);

    // Asynchronous reset mid-stream.
    res_ready = 1'b0;
    offer(32'h500, 32'h10, 1, 1, BR_BEQ, 1'b0); step; req_valid = 1'b0;
    step;
    res_ready = 1'b1; #1;
    check_eq("s7_pre_redir", redirect_valid, 1);
    rst_n = 1'b0; #1;
    check_eq("s7_rst_valid", res_valid, 0);
    check_eq("s7_rst_redir", redirect_valid, 0);
    check_eq("s7_rst_pc", res_pc, 0);
    check_eq("s7_rst_target", redirect_pc, 0);
    check_eq("s7_rst_taken", res_taken, 0);
    check_eq("s7_rst_cnt", cnt_branches, 0);
    @(negedge clk); rst_n = 1'b1;
    step;

    // Saturation at all-ones.
    test_cnt_load = 1'b1; test_cnt_value = 32'hFFFF_FFFF;
    step; test_cnt_load = 1'b0;
    check_eq("s8_preload", cnt_branches, 32'hFFFF_FFFF);
    offer(32'h600, 0, 1, 1, BR_BEQ, 1'b0); step; req_valid = 1'b0;
    step;
    check_eq("s8_loaded", res_valid, 1);
    step;
    check_eq("s8_sat_br", cnt_branches, 32'hFFFF_FFFF);
    check_eq("s8_sat_mis", cnt_mispredict, 32'hFFFF_FFFF);
    check_eq("s8_resolved", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
